// File: rtl/token_pkg.sv
// Shared constants, types and factor clamping for the serial token multiplier.
// Pure declarations; no state, no latency.
package token_pkg;

  localparam int MAX_FACTOR  = 4;
  localparam int MAX_PENDING = 200;
  localparam int FW          = $clog2(MAX_FACTOR + 1);
  localparam int PW          = $clog2(MAX_PENDING + 1);

  typedef logic [FW-1:0] factor_t;
  typedef logic [PW-1:0] pend_t;

  // factor 0 behaves as 1; anything above MAX_FACTOR is limited to MAX_FACTOR
  function automatic factor_t clamp_factor(input factor_t factor);
    if (factor == '0) return factor_t'(1);
    if (factor > factor_t'(MAX_FACTOR)) return factor_t'(MAX_FACTOR);
    return factor;
  endfunction

endpackage

// File: rtl/multiply_tokens_if.sv
// Token stream bundle: input tokens with per-token factor, expanded output tokens and status.
// Plain wires; the master drives a/factor, the slave returns b/overflow/pending.
interface multiply_tokens_if;
  import token_pkg::*;

  logic    a;
  factor_t factor;
  logic    b;
  logic    overflow;
  pend_t   pending;

  modport master (output a, factor, input b, overflow, pending);
  modport slave  (input a, factor, output b, overflow, pending);

endinterface

// File: rtl/token_credit_counter.sv
// Saturating credit counter: adds inc_amt or removes one credit per cycle, clamps at MAX_PENDING.
// Count is registered (one-cycle update); sat_hit is combinational from this cycle's inputs.
module token_credit_counter #(
  parameter int MAX_PENDING = 200,
  parameter int PW          = 8,
  parameter int FW          = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_en,
  input  logic [FW-1:0] inc_amt,
  input  logic          dec_en,
  output logic [PW-1:0] count,
  output logic          sat_hit
);

  localparam int RW = PW + FW;
  localparam logic [RW-1:0] MAX_RAW = RW'(MAX_PENDING);

  logic [PW-1:0] count_q;
  logic [RW-1:0] cnt_ext;
  logic [RW-1:0] raw;

  // widened so count + inc_amt can exceed the limit without wrapping
  assign cnt_ext = {{FW{1'b0}}, count_q};

  always_comb begin
    raw = cnt_ext;
    if (inc_en) begin
      raw = cnt_ext + {{PW{1'b0}}, inc_amt};
    end else if (dec_en && (count_q != '0)) begin
      raw = cnt_ext - RW'(1);
    end
  end

  assign sat_hit = (raw > MAX_RAW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= sat_hit ? MAX_RAW[PW-1:0] : raw[PW-1:0];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multiply_tokens.sv
// Serial token multiplier: each input token becomes f_eff output tokens, surplus held as credit.
// b is zero-latency from a and held credit; no backpressure, excess credit sets sticky overflow.
module multiply_tokens
  import token_pkg::*;
(
  input logic             clk,
  input logic             rst,
  multiply_tokens_if.slave io
);

  factor_t inc_amt;
  pend_t   count;
  logic    sat_hit;
  logic    overflow_q;

  // the token itself goes out this cycle, so only f_eff-1 becomes credit
  assign inc_amt = clamp_factor(io.factor) - factor_t'(1);

  token_credit_counter #(
    .MAX_PENDING (MAX_PENDING),
    .PW          (PW),
    .FW          (FW)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (io.a),
    .inc_amt (inc_amt),
    .dec_en  (!io.a),
    .count   (count),
    .sat_hit (sat_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (io.a && sat_hit) begin
      overflow_q <= 1'b1;
    end
  end

  assign io.b        = io.a | (count != '0);
  assign io.pending  = count;
  assign io.overflow = overflow_q;

endmodule

// File: tb/tb_multiply_tokens.sv
// Directed and random stimulus for multiply_tokens, checked against a credit-count model.
module tb_multiply_tokens;
  import token_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   m_pend;
  logic m_ovf;
  logic last_b;
  int   bcount;

  multiply_tokens_if tif ();

  multiply_tokens dut (
    .clk (clk),
    .rst (rst),
    .io  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: entered 1 time unit after a rising edge, leaves 1 unit after the next one.
  task automatic step(input logic ai, input int fi);
    int f;
    int raw;
    tif.a      = ai;
    tif.factor = factor_t'(fi);
    #3;
    chk("b", 32'(tif.b), 32'(ai | (m_pend != 0)));
    last_b = tif.b;
    if (tif.b === 1'b1) bcount++;
    f = (fi == 0) ? 1 : ((fi > MAX_FACTOR) ? MAX_FACTOR : fi);
    if (ai) begin
      raw = m_pend + f - 1;
      if (raw > MAX_PENDING) m_ovf = 1'b1;
    end else begin
      raw = (m_pend > 0) ? m_pend - 1 : 0;
    end
    m_pend = (raw > MAX_PENDING) ? MAX_PENDING : raw;
    @(posedge clk);
    #1;
    chk("pending", 32'(tif.pending), 32'(m_pend));
    chk("overflow", 32'(tif.overflow), 32'(m_ovf));
  endtask

  // Reset pulse strictly between edges; effect must be visible before the next edge.
  task automatic pulse_rst();
    tif.a = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_pending", 32'(tif.pending), 32'd0);
    chk("rst_overflow", 32'(tif.overflow), 32'd0);
    chk("rst_b", 32'(tif.b), 32'd0);
    #1;
    rst    = 1'b0;
    m_pend = 0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [25:0] a_vec;
    logic [25:0] b_vec;
    int          exp_p6 [12];
    n_chk  = 0;
    n_fail = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
    bcount = 0;
    last_b = 1'b0;
    rst    = 1'b1;
    tif.a  = 1'b0;
    tif.factor = '0;
    #1;
    chk("reset_pending", 32'(tif.pending), 32'd0);
    chk("reset_overflow", 32'(tif.overflow), 32'd0);
    chk("reset_b", 32'(tif.b), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: factor 2 over a fixed pattern
    a_vec = 26'b10010011000110100001100100;
    b_vec = 26'b11011011110111111001111110;
    for (int i = 0; i < 26; i++) begin
      step(a_vec[25-i], 2);
      chk("t1_b", 32'(last_b), 32'(b_vec[25-i]));
    end
    chk("t1_overflow", 32'(tif.overflow), 32'd0);

    // 2: factor 3, single token
    step(1'b1, 3); chk("t2_b0", 32'(last_b), 32'd1); chk("t2_p0", 32'(tif.pending), 32'd2);
    step(1'b0, 3); chk("t2_b1", 32'(last_b), 32'd1); chk("t2_p1", 32'(tif.pending), 32'd1);
    step(1'b0, 3); chk("t2_b2", 32'(last_b), 32'd1); chk("t2_p2", 32'(tif.pending), 32'd0);
    step(1'b0, 3); chk("t2_b3", 32'(last_b), 32'd0);

    // 3: factor 0 acts as 1, factor 7 clamps to 4
    bcount = 0;
    step(1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 0);
    chk("t3_ones_f0", 32'(bcount), 32'd1);
    bcount = 0;
    step(1'b1, 7);
    for (int i = 0; i < 5; i++) step(1'b0, 7);
    chk("t3_ones_f7", 32'(bcount), 32'd4);

    // 4: exactly MAX_PENDING tokens at factor 2 fit; one more overflows
    bcount = 0;
    for (int i = 0; i < 200; i++) step(1'b1, 2);
    chk("t4_pend200", 32'(tif.pending), 32'd200);
    chk("t4_no_ovf", 32'(tif.overflow), 32'd0);
    for (int i = 0; i < 205; i++) step(1'b0, 2);
    chk("t4_ones400", 32'(bcount), 32'd400);
    chk("t4_no_ovf_end", 32'(tif.overflow), 32'd0);
    pulse_rst();
    for (int i = 0; i < 201; i++) step(1'b1, 2);
    chk("t4_ovf201", 32'(tif.overflow), 32'd1);
    chk("t4_sat", 32'(tif.pending), 32'd200);
    for (int i = 0; i < 50; i++) step(1'b0, 2);
    chk("t4_ovf_sticky", 32'(tif.overflow), 32'd1);
    chk("t4_drain50", 32'(tif.pending), 32'd150);

    // 5: async reset while overflowed, then b follows a
    pulse_rst();
    step(1'b1, 1); chk("t5_b1", 32'(last_b), 32'd1);
    step(1'b0, 1); chk("t5_b0", 32'(last_b), 32'd0);
    step(1'b1, 1); chk("t5_b1b", 32'(last_b), 32'd1);

    // 6: factor change mid-burst does not rescale held credit
    exp_p6 = '{3, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    bcount = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 4, (i < 2) ? 4 : 1);
      chk("t6_pending", 32'(tif.pending), 32'(exp_p6[i]));
    end
    chk("t6_ones10", 32'(bcount), 32'd10);

    // random traffic, dense enough to reach saturation
    pulse_rst();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)));
      if (i == 200) pulse_rst();
    end
    for (int i = 0; i < 210; i++) step(1'b0, 0);
    chk("rand_drained", 32'(tif.pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
